// File: rtl/retire_buffer.sv
// Retire buffer: in-order allocation, out-of-order writeback, in-order
// presentation of the oldest completed entries to the commit stage.
// The supporting configuration and type packages come first so the design
// compiles on its own.

package config_pkg;
  typedef struct packed {
    int unsigned NrCommitPorts;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 2};
endpackage

package riscv;
  localparam int unsigned XLEN = 64;
endpackage

package ariane_pkg;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [riscv::XLEN-1:0] cause;
    logic [riscv::XLEN-1:0] tval;
    logic                   valid;
  } exception_t;

  typedef struct packed {
    logic [riscv::XLEN-1:0]   pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [3:0]               fu;
    logic [7:0]               op;
    logic [4:0]               rd;
    logic [riscv::XLEN-1:0]   result;
    logic                     valid;
    exception_t               ex;
  } scoreboard_entry_t;
endpackage

module retire_buffer
  import ariane_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg     = config_pkg::cva6_cfg_empty,
  parameter int unsigned           NR_ENTRIES  = 8,
  parameter int unsigned           NR_WB_PORTS = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         flush_i,
  input  logic                                         issue_valid_i,
  input  scoreboard_entry_t                            issue_entry_i,
  output logic                                         issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                     issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                       wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][riscv::XLEN-1:0]      wb_result_i,
  input  exception_t [NR_WB_PORTS-1:0]                 wb_ex_i,
  output scoreboard_entry_t [CVA6Cfg.NrCommitPorts-1:0] commit_instr_o,
  input  logic [CVA6Cfg.NrCommitPorts-1:0]             commit_ack_i
);

  localparam int unsigned       NR_COMMIT = CVA6Cfg.NrCommitPorts;
  localparam int unsigned       CNT_W     = TRANS_ID_BITS + 1;
  localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(NR_ENTRIES);

  logic [NR_ENTRIES-1:0]    occupied_q;
  logic [NR_ENTRIES-1:0]    done_q;
  scoreboard_entry_t        mem_q [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0] head_q;
  logic [TRANS_ID_BITS-1:0] tail_q;
  logic [CNT_W-1:0]         count_q;

  logic                     issue_fire;
  logic [NR_COMMIT-1:0]     commit_valid;
  logic [CNT_W-1:0]         retire_cnt;
  logic                     valid_chain;
  logic                     ack_chain;

  // Issue handshake: readiness depends on the registered count only.
  always_comb begin
    issue_ready_o    = (count_q < DEPTH);
    issue_trans_id_o = tail_q;
    issue_fire       = issue_valid_i & issue_ready_o;
  end

  // Present the oldest entries; a port is valid only if every older port is.
  always_comb begin
    commit_instr_o = '0;
    commit_valid   = '0;
    valid_chain    = 1'b1;
    for (int unsigned i = 0; i < NR_COMMIT; i++) begin
      valid_chain = valid_chain
                  & occupied_q[head_q + TRANS_ID_BITS'(i)]
                  & done_q[head_q + TRANS_ID_BITS'(i)];
      commit_valid[i]         = valid_chain;
      commit_instr_o[i]       = mem_q[head_q + TRANS_ID_BITS'(i)];
      commit_instr_o[i].valid = valid_chain;
    end
  end

  // Retire count: contiguous acknowledges from port 0 on valid ports only.
  always_comb begin
    ack_chain  = 1'b1;
    retire_cnt = '0;
    for (int unsigned i = 0; i < NR_COMMIT; i++) begin
      ack_chain  = ack_chain & commit_ack_i[i] & commit_valid[i];
      retire_cnt = retire_cnt + CNT_W'(ack_chain);
    end
  end

  // Buffer state: reset/flush first, then writeback, retire and issue.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      occupied_q <= '0;
      done_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      // Ascending port order lets the highest-index port win on a collision.
      for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_valid_i[p] && occupied_q[wb_trans_id_i[p]]) begin
          mem_q[wb_trans_id_i[p]].result <= wb_result_i[p];
          done_q[wb_trans_id_i[p]]       <= 1'b1;
          if (wb_ex_i[p].valid) begin
            mem_q[wb_trans_id_i[p]].ex <= wb_ex_i[p];
          end
        end
      end

      for (int unsigned i = 0; i < NR_COMMIT; i++) begin
        if (CNT_W'(i) < retire_cnt) begin
          occupied_q[head_q + TRANS_ID_BITS'(i)] <= 1'b0;
        end
      end

      if (issue_fire) begin
        mem_q[tail_q]          <= issue_entry_i;
        mem_q[tail_q].trans_id <= tail_q;
        mem_q[tail_q].ex.valid <= 1'b0;
        occupied_q[tail_q]     <= 1'b1;
        done_q[tail_q]         <= 1'b0;
        tail_q                 <= tail_q + TRANS_ID_BITS'(1);
      end

      head_q  <= head_q + TRANS_ID_BITS'(retire_cnt);
      count_q <= count_q + CNT_W'(issue_fire) - retire_cnt;
    end
  end

endmodule

// File: tb/tb_retire_buffer.sv
// Bench for retire_buffer: directed scenarios plus random traffic, all
// checked against a program-order queue model of the buffer.
module tb_retire_buffer;
  import ariane_pkg::*;

  localparam int unsigned NC    = config_pkg::cva6_cfg_empty.NrCommitPorts;
  localparam int unsigned NWB   = 2;
  localparam int unsigned DEPTH = 8;

  logic                                clk = 1'b0;
  logic                                rst;
  logic                                flush;
  logic                                issue_valid;
  scoreboard_entry_t                   issue_entry;
  logic                                issue_ready;
  logic [TRANS_ID_BITS-1:0]            issue_trans_id;
  logic [NWB-1:0]                      wb_valid;
  logic [NWB-1:0][TRANS_ID_BITS-1:0]   wb_trans_id;
  logic [NWB-1:0][riscv::XLEN-1:0]     wb_result;
  exception_t [NWB-1:0]                wb_ex;
  scoreboard_entry_t [NC-1:0]          commit_instr;
  logic [NC-1:0]                       commit_ack;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: entries in program order, oldest at the front.
  typedef struct {
    scoreboard_entry_t e;
    bit                done;
  } mdl_t;
  mdl_t q[$];
  int   next_id = 0;

  retire_buffer #(
    .CVA6Cfg    (config_pkg::cva6_cfg_empty),
    .NR_ENTRIES (DEPTH),
    .NR_WB_PORTS(NWB)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .issue_valid_i   (issue_valid),
    .issue_entry_i   (issue_entry),
    .issue_ready_o   (issue_ready),
    .issue_trans_id_o(issue_trans_id),
    .wb_valid_i      (wb_valid),
    .wb_trans_id_i   (wb_trans_id),
    .wb_result_i     (wb_result),
    .wb_ex_i         (wb_ex),
    .commit_instr_o  (commit_instr),
    .commit_ack_i    (commit_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic scoreboard_entry_t rand_entry();
    scoreboard_entry_t e;
    e.pc       = {$urandom, $urandom};
    e.trans_id = TRANS_ID_BITS'($urandom);
    e.fu       = 4'($urandom);
    e.op       = 8'($urandom);
    e.rd       = 5'($urandom);
    e.result   = {$urandom, $urandom};
    e.valid    = 1'($urandom);
    e.ex.cause = {$urandom, $urandom};
    e.ex.tval  = {$urandom, $urandom};
    e.ex.valid = 1'($urandom);
    return e;
  endfunction

  task automatic idle();
    rst         = 1'b0;
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_entry = '0;
    wb_valid    = '0;
    wb_trans_id = '0;
    wb_result   = '0;
    wb_ex       = '0;
    commit_ack  = '0;
  endtask

  task automatic set_issue();
    issue_valid = 1'b1;
    issue_entry = rand_entry();
  endtask

  task automatic set_wb(input int p, input int id);
    wb_valid[p]    = 1'b1;
    wb_trans_id[p] = TRANS_ID_BITS'(id);
    wb_result[p]   = {$urandom, $urandom};
    wb_ex[p]       = '0;
  endtask

  // Apply one clock edge of the buffer's rules to the queue model.
  task automatic model_update();
    int pre_size;
    int rc;
    bit chain;
    mdl_t m;
    if (rst || flush) begin
      q.delete();
      next_id = 0;
      return;
    end
    pre_size = q.size();
    rc    = 0;
    chain = 1'b1;
    for (int i = 0; i < NC; i++) begin
      chain = chain && (i < q.size()) && q[i].done && commit_ack[i];
      if (chain) rc++;
    end
    for (int p = 0; p < NWB; p++) begin
      if (wb_valid[p]) begin
        for (int k = 0; k < q.size(); k++) begin
          if (q[k].e.trans_id == wb_trans_id[p]) begin
            q[k].e.result = wb_result[p];
            q[k].done     = 1'b1;
            if (wb_ex[p].valid) q[k].e.ex = wb_ex[p];
          end
        end
      end
    end
    repeat (rc) void'(q.pop_front());
    if (issue_valid && pre_size < DEPTH) begin
      m.e          = issue_entry;
      m.e.trans_id = TRANS_ID_BITS'(next_id);
      m.e.ex.valid = 1'b0;
      m.done       = 1'b0;
      q.push_back(m);
      next_id = (next_id + 1) % DEPTH;
    end
  endtask

  task automatic check_outputs();
    bit chain;
    check_eq("ready", issue_ready, q.size() < DEPTH);
    check_eq("trans_id", issue_trans_id, next_id);
    chain = 1'b1;
    for (int i = 0; i < NC; i++) begin
      chain = chain && (i < q.size()) && q[i].done;
      check_eq($sformatf("c%0d_valid", i), commit_instr[i].valid, chain);
      if (chain) begin
        check_eq($sformatf("c%0d_pc", i), commit_instr[i].pc, q[i].e.pc);
        check_eq($sformatf("c%0d_tid", i), commit_instr[i].trans_id, q[i].e.trans_id);
        check_eq($sformatf("c%0d_result", i), commit_instr[i].result, q[i].e.result);
        check_eq($sformatf("c%0d_exv", i), commit_instr[i].ex.valid, q[i].e.ex.valid);
        check_eq($sformatf("c%0d_cause", i), commit_instr[i].ex.cause, q[i].e.ex.cause);
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked at the next one.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    idle();
  endtask

  task automatic rand_inputs();
    idle();
    rst         = ($urandom_range(0, 199) == 0);
    flush       = ($urandom_range(0, 59) == 0);
    issue_valid = ($urandom_range(0, 3) != 0);
    issue_entry = rand_entry();
    for (int p = 0; p < NWB; p++) begin
      wb_valid[p] = ($urandom_range(0, 2) == 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        wb_trans_id[p] = q[$urandom_range(0, q.size() - 1)].e.trans_id;
      else
        wb_trans_id[p] = TRANS_ID_BITS'($urandom);
      wb_result[p] = {$urandom, $urandom};
      wb_ex[p]     = '0;
      if ($urandom_range(0, 7) == 0) begin
        wb_ex[p].valid = 1'b1;
        wb_ex[p].cause = {$urandom, $urandom};
        wb_ex[p].tval  = {$urandom, $urandom};
      end
    end
    for (int i = 0; i < NC; i++) commit_ack[i] = ($urandom_range(0, 3) != 0);
  endtask

  logic [63:0] saved_pc;

  initial begin
    idle();
    @(negedge clk);

    // Reset state
    do_reset();
    check_eq("rst_ready", issue_ready, 1'b1);
    check_eq("rst_tid", issue_trans_id, 0);
    check_eq("rst_c0_valid", commit_instr[0].valid, 1'b0);

    // Fill without writeback
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("fill_tid", issue_trans_id, i);
      set_issue();
      cycle();
    end
    idle();
    check_eq("fill_ready", issue_ready, 1'b0);
    check_eq("fill_c0_valid", commit_instr[0].valid, 1'b0);

    // Out-of-order writeback, partial and dual acknowledge
    do_reset();
    repeat (3) begin set_issue(); cycle(); end
    idle(); set_wb(0, 2); cycle();
    check_eq("ooo_c0_early", commit_instr[0].valid, 1'b0);
    idle(); set_wb(1, 0); cycle();
    check_eq("ooo_c0", commit_instr[0].valid, 1'b1);
    check_eq("ooo_c1", commit_instr[1].valid, 1'b0);
    saved_pc = commit_instr[0].pc;
    idle(); set_wb(0, 1); cycle();
    idle(); commit_ack = 2'b10; cycle();
    check_eq("ack10_pc", commit_instr[0].pc, saved_pc);
    idle(); commit_ack = 2'b11; cycle();
    check_eq("ack11_tid", commit_instr[0].trans_id, 2);
    check_eq("ack11_valid", commit_instr[0].valid, 1'b1);

    // Full buffer with simultaneous issue and single retire
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin set_issue(); cycle(); end
    idle(); set_wb(0, 0); cycle();
    check_eq("full_ready", issue_ready, 1'b0);
    idle(); set_issue(); commit_ack = 2'b01; cycle();
    check_eq("fr_ready", issue_ready, 1'b1);
    idle(); set_issue(); cycle();
    check_eq("fr_full_again", issue_ready, 1'b0);

    // Flush with writeback, acknowledge and issue in the same cycle
    do_reset();
    repeat (5) begin set_issue(); cycle(); end
    idle(); set_wb(0, 0); set_wb(1, 1); cycle();
    idle(); flush = 1'b1; set_issue(); set_wb(0, 2); commit_ack = 2'b11; cycle();
    check_eq("flush_ready", issue_ready, 1'b1);
    check_eq("flush_tid", issue_trans_id, 0);
    check_eq("flush_c0", commit_instr[0].valid, 1'b0);
    idle(); set_wb(0, 2); cycle();
    check_eq("flush_wb_old", commit_instr[0].valid, 1'b0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rand_inputs();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
